// File: rtl/uart_sdma_arbiter_if.sv
// Handshake bundle between the UART pair / SDMA channel and the round-robin arbiter.
// The arbiter binds to the slave modport; the driving side (UARTs + SDMA) binds to master.
interface uart_sdma_arbiter_if #(
    parameter int unsigned XFER_CNT_WIDTH = 8
);
    logic [1:0]                UART_Dma_Req_i;
    logic [1:0]                UART_Dma_Gnt_o;
    logic [1:0]                UART_Dma_Done_o;
    logic                      SDMA_Req_o;
    logic                      SDMA_Active_i;
    logic                      SDMA_Done_i;
    logic                      Arb_Busy_o;
    logic                      Timeout_o;
    logic                      Timeout_Sticky_o;
    logic [XFER_CNT_WIDTH-1:0] Xfer_Cnt0_o;
    logic [XFER_CNT_WIDTH-1:0] Xfer_Cnt1_o;

    modport slave (
        input  UART_Dma_Req_i, SDMA_Active_i, SDMA_Done_i,
        output UART_Dma_Gnt_o, UART_Dma_Done_o, SDMA_Req_o, Arb_Busy_o,
               Timeout_o, Timeout_Sticky_o, Xfer_Cnt0_o, Xfer_Cnt1_o
    );

    modport master (
        output UART_Dma_Req_i, SDMA_Active_i, SDMA_Done_i,
        input  UART_Dma_Gnt_o, UART_Dma_Done_o, SDMA_Req_o, Arb_Busy_o,
               Timeout_o, Timeout_Sticky_o, Xfer_Cnt0_o, Xfer_Cnt1_o
    );
endinterface

// File: rtl/uart_sdma_arbiter.sv
// Round-robin arbiter sharing one SDMA channel between two UART RX-drain requests.
// Optional stall watchdog enabled by defining UART_SDMA_ARB_TIMEOUT_EN.
module uart_sdma_arbiter #(
    parameter int unsigned              TIMEOUT_WIDTH  = 10,
    parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_CYCLES = 10'd1000,
    parameter int unsigned              XFER_CNT_WIDTH = 8
) (
    input  logic               WB_CLK,
    input  logic               WB_RST,
    uart_sdma_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, REQ, ACTIVE, DONE} state_e;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_e                    state_q, state_d;
    logic                      owner_q, owner_d;
    logic                      last_owner_q, last_owner_d;
    logic [1:0]                gnt_q, gnt_d;
    logic [1:0]                done_q, done_d;
    logic                      sdma_req_q, sdma_req_d;
    logic                      busy_q, busy_d;
    logic [XFER_CNT_WIDTH-1:0] cnt0_q, cnt0_d;
    logic [XFER_CNT_WIDTH-1:0] cnt1_q, cnt1_d;
`ifdef UART_SDMA_ARB_TIMEOUT_EN
    logic [TIMEOUT_WIDTH-1:0]  wd_q, wd_d;
    logic                      timeout_q, timeout_d;
    logic                      sticky_q, sticky_d;
`endif

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        gnt_d        = gnt_q;
        done_d       = 2'b00;
        sdma_req_d   = sdma_req_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;
`ifdef UART_SDMA_ARB_TIMEOUT_EN
        wd_d         = wd_q;
        timeout_d    = 1'b0;
        sticky_d     = sticky_q;
`endif

        case (state_q)
            IDLE: begin
                case (bus.UART_Dma_Req_i)
                    2'b01:   owner_d = 1'b0;
                    2'b10:   owner_d = 1'b1;
                    2'b11:   owner_d = ~last_owner_q;
                    default: owner_d = owner_q;
                endcase
                if (bus.UART_Dma_Req_i != 2'b00) begin
                    state_d    = REQ;
                    gnt_d      = owner_d ? 2'b10 : 2'b01;
                    sdma_req_d = 1'b1;
`ifdef UART_SDMA_ARB_TIMEOUT_EN
                    wd_d       = '0;
`endif
                end
            end
            REQ: begin
                if (bus.SDMA_Done_i) begin
                    state_d = DONE;
                end else if (bus.SDMA_Active_i) begin
                    state_d    = ACTIVE;
                    sdma_req_d = 1'b0;
                end
            end
            ACTIVE: begin
                if (bus.SDMA_Done_i) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        // Completion is booked on entry to DONE so the pulse and counter land together.
        if (state_q == REQ || state_q == ACTIVE) begin
            if (state_d == DONE) begin
                gnt_d           = 2'b00;
                sdma_req_d      = 1'b0;
                done_d[owner_q] = 1'b1;
                last_owner_d    = owner_q;
                if (owner_q) cnt1_d = cnt1_q + 1'b1;
                else         cnt0_d = cnt0_q + 1'b1;
            end
`ifdef UART_SDMA_ARB_TIMEOUT_EN
            wd_d = wd_q + 1'b1;
            // Fires on the TIMEOUT_CYCLES-th cycle spent in REQ/ACTIVE; a coincident Done wins.
            if (!bus.SDMA_Done_i && wd_q == TIMEOUT_CYCLES - 1'b1) begin
                state_d      = IDLE;
                gnt_d        = 2'b00;
                sdma_req_d   = 1'b0;
                last_owner_d = owner_q;
                timeout_d    = 1'b1;
                sticky_d     = 1'b1;
            end
`endif
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge WB_CLK) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (WB_RST) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            gnt_q        <= 2'b00;
            done_q       <= 2'b00;
            sdma_req_q   <= 1'b0;
            busy_q       <= 1'b0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
`ifdef UART_SDMA_ARB_TIMEOUT_EN
            wd_q         <= '0;
            timeout_q    <= 1'b0;
            sticky_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            gnt_q        <= gnt_d;
            done_q       <= done_d;
            sdma_req_q   <= sdma_req_d;
            busy_q       <= busy_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
`ifdef UART_SDMA_ARB_TIMEOUT_EN
            wd_q         <= wd_d;
            timeout_q    <= timeout_d;
            sticky_q     <= sticky_d;
`endif
        end
    end

    assign bus.UART_Dma_Gnt_o   = gnt_q;
    assign bus.UART_Dma_Done_o  = done_q;
    assign bus.SDMA_Req_o       = sdma_req_q;
    assign bus.Arb_Busy_o       = busy_q;
    assign bus.Xfer_Cnt0_o      = cnt0_q;
    assign bus.Xfer_Cnt1_o      = cnt1_q;
`ifdef UART_SDMA_ARB_TIMEOUT_EN
    assign bus.Timeout_o        = timeout_q;
    assign bus.Timeout_Sticky_o = sticky_q;
`else
    assign bus.Timeout_o        = 1'b0;
    assign bus.Timeout_Sticky_o = 1'b0;
`endif

endmodule
